// File: rtl/axi4lite_rd_burst_bridge.sv
// ---------------------------------------------------------------------------
// axi4lite_rd_burst_bridge
//
// Purpose:
//   Read-path bridge from AXI4 to AXI4-Lite. It accepts one AXI4 AR burst at a
//   time (FIXED, INCR or WRAP, len 0..255). It splits the burst into len+1
//   single-beat Lite reads, with up to MAX_OUT reads in flight. It returns the
//   Lite responses as an AXI4 R burst that carries the original ID, with
//   RLAST set on the final beat. An illegal burst is not forwarded to the
//   Lite side. It is answered locally with len+1 SLVERR beats.
//
// Optional feature (compile-time macro AXI4LITE_RD_BRIDGE_STICKY_RESP_EN):
//   Defined   - once a beat returns a non-OKAY response, every later beat of
//               the same burst reports the worst response seen so far.
//   Undefined - every beat reports its own Lite response.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   i_s_ar_* / o_s_ar_ready   AXI4 read address channel (slave side)
//   o_s_r_* / i_s_r_ready     AXI4 read data channel (slave side)
//   o_m_ar_* / i_m_ar_ready   AXI4-Lite read address channel (master side)
//   i_m_r_* / o_m_r_ready     AXI4-Lite read data channel (master side)
//   o_dbg_state               current FSM state (0 IDLE, 1 ISSUE, 2 ERR)
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holds valid and its payload
// stable until that edge. A source never waits for ready before it raises
// valid. In ISSUE the R path is a zero-latency combinational pass-through
// from the Lite side to the AXI4 side.
// ---------------------------------------------------------------------------
module axi4lite_rd_burst_bridge #(
    parameter int ID_W    = 5,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_s_ar_valid,
    output logic              o_s_ar_ready,
    input  logic [ID_W-1:0]   i_s_ar_id,
    input  logic [ADDR_W-1:0] i_s_ar_addr,
    input  logic [7:0]        i_s_ar_len,
    input  logic [2:0]        i_s_ar_size,
    input  logic [1:0]        i_s_ar_burst,
    input  logic [2:0]        i_s_ar_prot,
    output logic              o_s_r_valid,
    input  logic              i_s_r_ready,
    output logic [ID_W-1:0]   o_s_r_id,
    output logic [DATA_W-1:0] o_s_r_data,
    output logic [1:0]        o_s_r_resp,
    output logic              o_s_r_last,
    output logic              o_m_ar_valid,
    input  logic              i_m_ar_ready,
    output logic [ADDR_W-1:0] o_m_ar_addr,
    output logic [2:0]        o_m_ar_prot,
    input  logic              i_m_r_valid,
    output logic              o_m_r_ready,
    input  logic [DATA_W-1:0] i_m_r_data,
    input  logic [1:0]        i_m_r_resp,
    output logic [1:0]        o_dbg_state
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    localparam int OW       = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_s_ar_ready;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [2:0]        r_prot;
    logic [8:0]        r_issue_cnt;
    logic [8:0]        r_ret_cnt;
    logic [OW-1:0]     r_out_cnt;

    logic              w_issue;
    logic              w_err;
    logic              w_has_out;
    logic              w_m_ar_hs;
    logic              w_m_r_hs;
    logic              w_s_r_hs;
    logic              w_last;
    logic              w_bad_req;
    logic [1:0]        w_resp;

    logic [ADDR_W-1:0] w_size_mask;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_offs;
    logic [ADDR_W-1:0] w_total;
    logic [ADDR_W-1:0] w_wrap_mask;
    logic [ADDR_W-1:0] w_lower;
    logic [ADDR_W-1:0] w_wrap_addr;
    logic [ADDR_W-1:0] w_beat_addr;

    // A request is illegal if it uses the reserved burst type, if it is wider
    // than the data bus, or if it is a WRAP whose length is not 2/4/8/16 beats.
    assign w_bad_req = (i_s_ar_burst == 2'b11)
                    || (i_s_ar_size > 3'(MAX_SIZE))
                    || ((i_s_ar_burst == 2'b10)
                        && !(i_s_ar_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    // Beat address for beat index r_issue_cnt. All arithmetic is modulo
    // 2^ADDR_W. For a legal WRAP the total size is a power of two, so the
    // modulo reduces to a mask.
    assign w_size_mask = (ADDR_W'(1) << r_size) - ADDR_W'(1);
    assign w_aligned   = r_addr & ~w_size_mask;
    assign w_offs      = ADDR_W'(r_issue_cnt) << r_size;
    assign w_total     = (ADDR_W'(r_len) + ADDR_W'(1)) << r_size;
    assign w_wrap_mask = w_total - ADDR_W'(1);
    assign w_lower     = w_aligned & ~w_wrap_mask;
    assign w_wrap_addr = w_lower + ((w_aligned - w_lower + w_offs) & w_wrap_mask);

    always_comb begin
        w_beat_addr = r_addr;
        case (r_burst)
            2'b00:   w_beat_addr = r_addr;
            2'b10:   w_beat_addr = w_wrap_addr;
            // INCR: beat 0 keeps the unaligned start address.
            default: w_beat_addr = (r_issue_cnt == 9'd0) ? r_addr : (w_aligned + w_offs);
        endcase
    end

    assign w_issue   = (r_state == ST_ISSUE);
    assign w_err     = (r_state == ST_ERR);
    assign w_has_out = (r_out_cnt != '0);
    assign w_last    = (r_ret_cnt == {1'b0, r_len});

`ifdef AXI4LITE_RD_BRIDGE_STICKY_RESP_EN
    logic [1:0] r_sticky;
    // The numeric order of the codes matches severity: DECERR > SLVERR > OKAY.
    assign w_resp = (r_sticky > i_m_r_resp) ? r_sticky : i_m_r_resp;
`else
    assign w_resp = i_m_r_resp;
`endif

    assign o_m_ar_valid = w_issue && (r_issue_cnt <= {1'b0, r_len})
                       && (r_out_cnt < OW'(MAX_OUT));
    assign o_m_ar_addr  = w_issue ? w_beat_addr : '0;
    assign o_m_ar_prot  = r_prot;
    // R is passed through only while a Lite read is outstanding. A stray
    // Lite R beat stays blocked.
    assign o_m_r_ready  = w_issue && i_s_r_ready && w_has_out;
    assign o_s_r_valid  = (w_issue && i_m_r_valid && w_has_out) || w_err;
    assign o_s_r_data   = w_issue ? i_m_r_data : '0;
    assign o_s_r_resp   = w_issue ? w_resp : (w_err ? 2'b10 : 2'b00);
    assign o_s_r_last   = (w_issue || w_err) && w_last;
    assign o_s_r_id     = r_id;
    assign o_s_ar_ready = r_s_ar_ready;
    assign o_dbg_state  = r_state;

    assign w_m_ar_hs = o_m_ar_valid && i_m_ar_ready;
    assign w_m_r_hs  = o_m_r_ready && i_m_r_valid;
    assign w_s_r_hs  = o_s_r_valid && i_s_r_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_s_ar_ready <= 1'b0;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_prot       <= '0;
            r_issue_cnt  <= '0;
            r_ret_cnt    <= '0;
            r_out_cnt    <= '0;
`ifdef AXI4LITE_RD_BRIDGE_STICKY_RESP_EN
            r_sticky     <= 2'b00;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_s_ar_ready <= 1'b1;
                    if (i_s_ar_valid && r_s_ar_ready) begin
                        r_s_ar_ready <= 1'b0;
                        r_id         <= i_s_ar_id;
                        r_addr       <= i_s_ar_addr;
                        r_len        <= i_s_ar_len;
                        r_size       <= i_s_ar_size;
                        r_burst      <= i_s_ar_burst;
                        r_prot       <= i_s_ar_prot;
                        r_issue_cnt  <= '0;
                        r_ret_cnt    <= '0;
                        r_out_cnt    <= '0;
`ifdef AXI4LITE_RD_BRIDGE_STICKY_RESP_EN
                        r_sticky     <= 2'b00;
`endif
                        r_state      <= w_bad_req ? ST_ERR : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_m_ar_hs) begin
                        r_issue_cnt <= r_issue_cnt + 9'd1;
                    end
                    case ({w_m_ar_hs, w_m_r_hs})
                        2'b10:   r_out_cnt <= r_out_cnt + OW'(1);
                        2'b01:   r_out_cnt <= r_out_cnt - OW'(1);
                        default: r_out_cnt <= r_out_cnt;
                    endcase
                    if (w_m_r_hs) begin
                        r_ret_cnt <= r_ret_cnt + 9'd1;
`ifdef AXI4LITE_RD_BRIDGE_STICKY_RESP_EN
                        r_sticky  <= w_resp;
`endif
                        if (w_last) begin
                            r_state      <= ST_IDLE;
                            r_s_ar_ready <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    if (w_s_r_hs) begin
                        r_ret_cnt <= r_ret_cnt + 9'd1;
                        if (w_last) begin
                            r_state      <= ST_IDLE;
                            r_s_ar_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_rd_burst_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_rd_burst_bridge
//
// Directed bench for axi4lite_rd_burst_bridge, built with MAX_OUT=2.
// The Lite side is a small slave model. It returns data derived from the
// beat address, together with a scripted response per beat. The scoreboard
// queues hold hand-computed beat addresses, data, responses and last flags.
// ---------------------------------------------------------------------------
module tb_axi4lite_rd_burst_bridge;

  localparam int ID_W    = 5;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              i_s_ar_valid;
  logic              o_s_ar_ready;
  logic [ID_W-1:0]   i_s_ar_id;
  logic [ADDR_W-1:0] i_s_ar_addr;
  logic [7:0]        i_s_ar_len;
  logic [2:0]        i_s_ar_size;
  logic [1:0]        i_s_ar_burst;
  logic [2:0]        i_s_ar_prot;
  logic              o_s_r_valid;
  logic              i_s_r_ready;
  logic [ID_W-1:0]   o_s_r_id;
  logic [DATA_W-1:0] o_s_r_data;
  logic [1:0]        o_s_r_resp;
  logic              o_s_r_last;
  logic              o_m_ar_valid;
  logic              i_m_ar_ready;
  logic [ADDR_W-1:0] o_m_ar_addr;
  logic [2:0]        o_m_ar_prot;
  logic              i_m_r_valid;
  logic              o_m_r_ready;
  logic [DATA_W-1:0] i_m_r_data;
  logic [1:0]        i_m_r_resp;
  logic [1:0]        o_dbg_state;

  axi4lite_rd_burst_bridge #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_s_ar_valid(i_s_ar_valid), .o_s_ar_ready(o_s_ar_ready),
    .i_s_ar_id(i_s_ar_id), .i_s_ar_addr(i_s_ar_addr), .i_s_ar_len(i_s_ar_len),
    .i_s_ar_size(i_s_ar_size), .i_s_ar_burst(i_s_ar_burst), .i_s_ar_prot(i_s_ar_prot),
    .o_s_r_valid(o_s_r_valid), .i_s_r_ready(i_s_r_ready), .o_s_r_id(o_s_r_id),
    .o_s_r_data(o_s_r_data), .o_s_r_resp(o_s_r_resp), .o_s_r_last(o_s_r_last),
    .o_m_ar_valid(o_m_ar_valid), .i_m_ar_ready(i_m_ar_ready),
    .o_m_ar_addr(o_m_ar_addr), .o_m_ar_prot(o_m_ar_prot),
    .i_m_r_valid(i_m_r_valid), .o_m_r_ready(o_m_r_ready),
    .i_m_r_data(i_m_r_data), .i_m_r_resp(i_m_r_resp),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        exp_resp_q[$];
  logic              exp_last_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [1:0]        lite_resp_q[$];
  logic [ADDR_W-1:0] lq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] lite_data(input logic [ADDR_W-1:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  // ---------------- bench state ----------------
  logic              rand_ar = 1'b0;
  logic              rand_r  = 1'b0;
  int                rv_hold = 0;
  logic              ar_req  = 1'b0;
  logic              ar_hs   = 1'b0;
  logic [ID_W-1:0]   n_id;
  logic [ADDR_W-1:0] n_addr;
  logic [7:0]        n_len;
  logic [2:0]        n_size;
  logic [1:0]        n_burst;
  logic [2:0]        n_prot;
  int                ar_count;
  int                s_beats;
  int                lite_r_count;
  int                r_at_ar3;
  int                out_model;
  int                max_out_seen;
  int                last_seen;

  task automatic new_test();
    ar_count     = 0;
    s_beats      = 0;
    lite_r_count = 0;
    r_at_ar3     = 0;
    last_seen    = 0;
    max_out_seen = 0;
  endtask

  task automatic push_beat(input logic [ADDR_W-1:0] a, input logic [1:0] lresp,
                           input logic [1:0] eresp, input logic last);
    exp_addr_q.push_back(a);
    exp_q.push_back(lite_data(a));
    lite_resp_q.push_back(lresp);
    exp_resp_q.push_back(eresp);
    exp_last_q.push_back(last);
  endtask

  task automatic push_err(input logic last);
    exp_q.push_back('0);
    exp_resp_q.push_back(2'b10);
    exp_last_q.push_back(last);
  endtask

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [2:0] prot);
    n_id = id; n_addr = a; n_len = len; n_size = size; n_burst = burst; n_prot = prot;
    ar_req = 1'b1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Inputs change on the falling edge. The handshakes that the next rising
  // edge will complete are evaluated 1 time unit later.
  task automatic step();
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    if (ar_hs) begin
      i_s_ar_valid = 1'b0;
      ar_hs = 1'b0;
    end
    if (ar_req) begin
      i_s_ar_valid = 1'b1;
      i_s_ar_id = n_id; i_s_ar_addr = n_addr; i_s_ar_len = n_len;
      i_s_ar_size = n_size; i_s_ar_burst = n_burst; i_s_ar_prot = n_prot;
      ar_req = 1'b0;
    end
    i_m_ar_ready = rand_ar ? 1'($urandom_range(0, 1)) : 1'b1;
    i_s_r_ready  = rand_r  ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rv_hold > 0) begin
      rv_hold--;
      i_m_r_valid = 1'b0;
    end else begin
      i_m_r_valid = (lq.size() > 0);
    end
    i_m_r_data = (lq.size() > 0) ? lite_data(lq[0]) : '0;
    i_m_r_resp = (lite_resp_q.size() > 0) ? lite_resp_q[0] : 2'b00;
    #1;
    if (i_s_ar_valid && o_s_ar_ready) ar_hs = 1'b1;
    if (o_s_r_valid && i_s_r_ready) begin
      if (exp_q.size() > 0) begin
        check("r_data", o_s_r_data, exp_q.pop_front());
        check("r_resp", o_s_r_resp, exp_resp_q.pop_front());
        check("r_last", o_s_r_last, exp_last_q.pop_front());
        check("r_id", o_s_r_id, n_id);
      end else begin
        check("r_extra_beat", exp_q.size(), 1);
      end
      if (o_s_r_last) last_seen++;
      s_beats++;
    end
    if (i_m_r_valid && o_m_r_ready) begin
      void'(lq.pop_front());
      if (lite_resp_q.size() > 0) void'(lite_resp_q.pop_front());
      out_model--;
      lite_r_count++;
    end
    if (o_m_ar_valid && i_m_ar_ready) begin
      if (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        check("m_ar_addr", o_m_ar_addr, ea);
        check("m_ar_prot", o_m_ar_prot, n_prot);
      end else begin
        check("m_ar_extra", exp_addr_q.size(), 1);
      end
      lq.push_back(o_m_ar_addr);
      ar_count++;
      if (ar_count == 3) r_at_ar3 = lite_r_count;
      out_model++;
    end
    if (out_model > max_out_seen) max_out_seen = out_model;
  endtask

  task automatic run_until(input string tag, input int beats, input int budget);
    int cyc = 0;
    while (s_beats < beats && cyc < budget) begin
      step();
      cyc++;
    end
    check({tag, "_beats"}, s_beats, beats);
  endtask

  task automatic check_rst(input string p);
    check({p, "_s_ar_ready"}, o_s_ar_ready, 0);
    check({p, "_s_r_valid"},  o_s_r_valid, 0);
    check({p, "_s_r_last"},   o_s_r_last, 0);
    check({p, "_s_r_resp"},   o_s_r_resp, 0);
    check({p, "_s_r_id"},     o_s_r_id, 0);
    check({p, "_s_r_data"},   o_s_r_data, 0);
    check({p, "_m_ar_valid"}, o_m_ar_valid, 0);
    check({p, "_m_r_ready"},  o_m_r_ready, 0);
    check({p, "_m_ar_addr"},  o_m_ar_addr, 0);
    check({p, "_m_ar_prot"},  o_m_ar_prot, 0);
    check({p, "_state"},      o_dbg_state, 0);
  endtask

  // Clears every model queue and applies a one-cycle reset.
  task automatic pulse_reset(input string p);
    @(negedge clk);
    rstn = 1'b0;
    i_s_ar_valid = 1'b0; i_m_r_valid = 1'b0; i_m_r_data = '0; i_m_r_resp = 2'b00;
    ar_hs = 1'b0; ar_req = 1'b0; rv_hold = 0;
    exp_q.delete(); exp_resp_q.delete(); exp_last_q.delete();
    exp_addr_q.delete(); lite_resp_q.delete(); lq.delete();
    out_model = 0;
    @(posedge clk);
    #1;
    check_rst(p);
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_s_ar_valid = 1'b0; i_s_ar_id = '0; i_s_ar_addr = '0; i_s_ar_len = '0;
    i_s_ar_size = '0; i_s_ar_burst = '0; i_s_ar_prot = '0;
    i_s_r_ready = 1'b0; i_m_ar_ready = 1'b0; i_m_r_valid = 1'b0;
    i_m_r_data = '0; i_m_r_resp = 2'b00;
    out_model = 0;
    new_test();

    repeat (2) @(posedge clk);
    #1;
    check_rst("rst");
    rstn = 1'b1;

    // INCR, unaligned start: 0x1004, 0x1008, 0x1010, 0x1018.
    new_test();
    push_beat(32'h1004, 2'b00, 2'b00, 1'b0);
    push_beat(32'h1008, 2'b00, 2'b00, 1'b0);
    push_beat(32'h1010, 2'b00, 2'b00, 1'b0);
    push_beat(32'h1018, 2'b00, 2'b00, 1'b1);
    send_ar(5'h0A, 32'h1004, 8'd3, 3'd3, 2'b01, 3'b010);
    run_until("incr", 4, 200);
    check("incr_ar_cnt", ar_count, 4);
    check("incr_last_cnt", last_seen, 1);

    // WRAP from 0x2018 over a 32-byte window: 0x2018, 0x2000, 0x2008, 0x2010.
    // Lite resps 00,10,11,00 pass through, or become 00,10,11,11 when sticky.
    new_test();
    push_beat(32'h2018, 2'b00, 2'b00, 1'b0);
    push_beat(32'h2000, 2'b10, 2'b10, 1'b0);
    push_beat(32'h2008, 2'b11, 2'b11, 1'b0);
`ifdef AXI4LITE_RD_BRIDGE_STICKY_RESP_EN
    push_beat(32'h2010, 2'b00, 2'b11, 1'b1);
`else
    push_beat(32'h2010, 2'b00, 2'b00, 1'b1);
`endif
    send_ar(5'h13, 32'h2018, 8'd3, 3'd3, 2'b10, 3'b101);
    run_until("wrap", 4, 200);
    check("wrap_ar_cnt", ar_count, 4);

    // FIXED with the Lite R channel stalled: only MAX_OUT=2 ARs are issued.
    new_test();
    push_beat(32'h300, 2'b00, 2'b00, 1'b0);
    push_beat(32'h300, 2'b00, 2'b00, 1'b0);
    push_beat(32'h300, 2'b00, 2'b00, 1'b1);
    rv_hold = 10;
    send_ar(5'h01, 32'h300, 8'd2, 3'd2, 2'b00, 3'b000);
    repeat (10) step();
    check("fixed_ar_cnt_stalled", ar_count, 2);
    run_until("fixed", 3, 200);
    check("fixed_ar3_after_r", (r_at_ar3 >= 1), 1);
    check("fixed_max_out", (max_out_seen <= MAX_OUT), 1);

    // Reserved burst type: 2 SLVERR beats, no Lite traffic.
    new_test();
    push_err(1'b0);
    push_err(1'b1);
    send_ar(5'h1F, 32'h400, 8'd1, 3'd2, 2'b11, 3'b000);
    run_until("err_rsv", 2, 100);
    check("err_rsv_ar_cnt", ar_count, 0);

    // WRAP with len=2 is illegal: 3 SLVERR beats.
    new_test();
    push_err(1'b0);
    push_err(1'b0);
    push_err(1'b1);
    send_ar(5'h02, 32'h500, 8'd2, 3'd2, 2'b10, 3'b000);
    run_until("err_wrap", 3, 100);
    check("err_wrap_ar_cnt", ar_count, 0);

    // Size wider than the 64-bit bus: 1 SLVERR beat.
    new_test();
    push_err(1'b1);
    send_ar(5'h03, 32'h600, 8'd0, 3'd4, 2'b01, 3'b000);
    run_until("err_size", 1, 100);
    check("err_size_ar_cnt", ar_count, 0);

    // INCR len=255, byte beats, random backpressure on both sides.
    new_test();
    for (int n = 0; n < 256; n++)
      push_beat(32'h4000_0080 + n, 2'b00, 2'b00, (n == 255));
    rand_ar = 1'b1;
    rand_r  = 1'b1;
    send_ar(5'h15, 32'h4000_0080, 8'd255, 3'd0, 2'b01, 3'b011);
    run_until("long", 256, 5000);
    rand_ar = 1'b0;
    rand_r  = 1'b0;
    check("long_ar_cnt", ar_count, 256);
    check("long_last_cnt", last_seen, 1);
    check("long_max_out", (max_out_seen <= MAX_OUT), 1);

    // Reset during beat 2 of a 4-beat burst, then a fresh burst.
    new_test();
    push_beat(32'h6000, 2'b00, 2'b00, 1'b0);
    push_beat(32'h6008, 2'b00, 2'b00, 1'b0);
    push_beat(32'h6010, 2'b00, 2'b00, 1'b0);
    push_beat(32'h6018, 2'b00, 2'b00, 1'b1);
    send_ar(5'h07, 32'h6000, 8'd3, 3'd3, 2'b01, 3'b001);
    run_until("pre_rst", 2, 100);
    pulse_reset("midrst");
    new_test();
    push_beat(32'h5000, 2'b00, 2'b00, 1'b0);
    push_beat(32'h5004, 2'b10, 2'b10, 1'b0);
`ifdef AXI4LITE_RD_BRIDGE_STICKY_RESP_EN
    push_beat(32'h5008, 2'b00, 2'b10, 1'b0);
    push_beat(32'h500C, 2'b00, 2'b10, 1'b1);
`else
    push_beat(32'h5008, 2'b00, 2'b00, 1'b0);
    push_beat(32'h500C, 2'b00, 2'b00, 1'b1);
`endif
    send_ar(5'h0C, 32'h5000, 8'd3, 3'd2, 2'b01, 3'b110);
    run_until("post_rst", 4, 200);
    check("post_rst_ar_cnt", ar_count, 4);
    check("post_rst_last_cnt", last_seen, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
